// File: rtl/uart_word_tx.sv
// uart_word_tx
// Multi-byte UART transmitter. A word of WORD_BYTES bytes is accepted on a
// tx_start request while idle and sent as WORD_BYTES back-to-back 8-bit
// frames, least-significant byte first, each with one start bit, optional
// parity and STOP_BITS stop bits. Bit timing comes from an internal counter,
// so every bit lasts exactly CLKS_PER_BIT clocks, phase-locked to the request.
//
// Optional feature macro: UART_WORD_TX_PARITY_EN
//   defined   -> each byte carries an even-parity bit after data bit 7
//   undefined -> plain 8-bit frames, no parity logic
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   tx_start  in   transmit request, sampled only while idle
//   data_in   in   8*WORD_BYTES word, sampled on the accepted request cycle
//   busy      out  high from the cycle after acceptance until word finished
//   data_over out  one-cycle pulse when the last stop bit completes
//   txd       out  registered serial line, idle high
module uart_word_tx #(
  parameter int WORD_BYTES   = 4,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_start,
  input  logic [8*WORD_BYTES-1:0] data_in,
  output logic                    busy,
  output logic                    data_over,
  output logic                    txd
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(WORD_BYTES - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_WORD_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic            stop_q, stop_d;
  logic [W-1:0]    shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef UART_WORD_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == CNT_LAST);

  // txd is computed one cycle ahead so the registered line changes exactly
  // on the edge where the state changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d = data_in;
          byte_d  = '0;
          state_d = S_START;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          txd_d   = shift_q[0];
`ifdef UART_WORD_TX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
`ifdef UART_WORD_TX_PARITY_EN
          par_d   = par_q ^ shift_q[0];
`endif
          if (bit_q == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q ^ shift_q[0];
`else
            state_d = S_STOP;
            stop_d  = 1'b0;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end
      end

`ifdef UART_WORD_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
          stop_d  = 1'b0;
          txd_d   = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop_q != STOP_LAST) begin
            stop_d = 1'b1;
          end else if (byte_q != BYTE_LAST) begin
            // Next byte is already in shift[7:0]; no idle gap between bytes.
            byte_d  = byte_q + 1'b1;
            state_d = S_START;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_WORD_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign txd       = txd_q;
  assign busy      = busy_q;
  assign data_over = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx with CLKS_PER_BIT=4. Default build: 4-byte words,
// 2 stop bits, no parity. With UART_WORD_TX_PARITY_EN: 1-byte words, 1 stop
// bit, even parity.
module tb_uart_word_tx;

  localparam int C = 4;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int WB    = 1;
  localparam int SB    = 1;
  localparam int PAR   = 1;
  localparam int TOTAL = 44;   // 1 byte * 11 bits * 4 clocks
`else
  localparam int WB    = 4;
  localparam int SB    = 2;
  localparam int PAR   = 0;
  localparam int TOTAL = 176;  // 4 bytes * 11 bits * 4 clocks
`endif
  localparam int W   = 8 * WB;
  localparam int B   = 1 + 8 + PAR + SB;
  localparam int IGN = (TOTAL > 60) ? 50 : 20;

  logic         clk;
  logic         rst;
  logic         tx_start;
  logic [W-1:0] data_in;
  logic         busy;
  logic         data_over;
  logic         txd;

  int vectors;
  int miscompares;

  logic tr_txd  [0:1023];
  logic tr_busy [0:1023];
  logic tr_do   [0:1023];

  uart_word_tx #(
    .WORD_BYTES  (WB),
    .CLKS_PER_BIT(C),
    .STOP_BITS   (SB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .data_in  (data_in),
    .busy     (busy),
    .data_over(data_over),
    .txd      (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Expected line level t cycles after acceptance of word w.
  function automatic logic exp_line(input logic [63:0] w, input int t);
    int f;
    int b;
    logic [7:0] by;
    if (t < 0 || t >= TOTAL) return 1'b1;
    f  = t / (B * C);
    b  = (t / C) % B;
    by = w[8*f +: 8];
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (PAR == 1 && b == 9) return ^by;
    return 1'b1;
  endfunction

  function automatic int wave_err(input logic [63:0] w, input int off, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi; i++)
      if (tr_txd[i] !== exp_line(w, i - off)) n++;
    return n;
  endfunction

  function automatic logic [7:0] decode_byte(input int off, input int f);
    logic [7:0] by;
    for (int j = 0; j < 8; j++)
      by[j] = tr_txd[off + f*B*C + (1+j)*C + C/2];
    return by;
  endfunction

  function automatic int cnt_busy(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi; i++) if (tr_busy[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int cnt_do(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi; i++) if (tr_do[i] !== 1'b0) n++;
    return n;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_word(input logic [W-1:0] w);
    tx_start = 1'b1;
    data_in  = w;
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    data_in  = ~w;
  endtask

  // Records n negedge samples; optionally drives a one-cycle request
  // (kind 1) or reset (kind 2) from sample index inj_idx.
  task automatic observe(input int n, input int inj_idx, input int kind, input logic [W-1:0] inj_w);
    for (int i = 0; i < n; i++) begin
      tr_txd[i]  = txd;
      tr_busy[i] = busy;
      tr_do[i]   = data_over;
      if (i == inj_idx) begin
        if (kind == 1) begin
          tx_start = 1'b1;
          data_in  = inj_w;
        end else if (kind == 2) begin
          rst = 1'b1;
        end
      end else if (i == inj_idx + 1) begin
        tx_start = 1'b0;
        rst      = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_start = 1'b0;
    data_in = '0;
    for (int i = 0; i < 23; i++) begin
      if (i < 3) @(posedge clk);
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      vectors++;
      if (txd !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_txd[%0d]: got %b expected 1", i, txd);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy);
      end
      vectors++;
      if (data_over !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_data_over[%0d]: got %b expected 0", i, data_over);
      end
    end
  endtask

  task automatic test_basic(input logic [W-1:0] w);
    int e;
    start_word(w);
    observe(TOTAL + 4, -10, 0, '0);
    vectors++;
    if (tr_txd[0] !== 1'b0 || tr_busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_accept: got txd=%b busy=%b expected txd=0 busy=1", tr_txd[0], tr_busy[0]);
    end
    e = wave_err(64'(w), 0, 0, TOTAL + 4);
    vectors++;
    if (e !== 0) begin
      miscompares++;
      $display("FAIL basic_wave: got %0d bad cycles expected 0", e);
    end
    for (int f = 0; f < WB; f++) begin
      vectors++;
      if (decode_byte(0, f) !== w[8*f +: 8]) begin
        miscompares++;
        $display("FAIL basic_byte%0d: got %h expected %h", f, decode_byte(0, f), w[8*f +: 8]);
      end
    end
    vectors++;
    if (cnt_busy(0, TOTAL + 4) !== TOTAL || tr_busy[TOTAL] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy_len: got %0d expected %0d", cnt_busy(0, TOTAL + 4), TOTAL);
    end
    vectors++;
    if (cnt_do(0, TOTAL + 4) !== 1 || tr_do[TOTAL] !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_data_over: got %0d pulses expected 1 at %0d", cnt_do(0, TOTAL + 4), TOTAL);
    end
  endtask

  task automatic test_ignored(input logic [W-1:0] w);
    int e;
    start_word(w);
    observe(TOTAL + 4, IGN, 1, '1);
    e = wave_err(64'(w), 0, 0, TOTAL + 4);
    vectors++;
    if (e !== 0) begin
      miscompares++;
      $display("FAIL ignored_wave: got %0d bad cycles expected 0", e);
    end
    vectors++;
    if (cnt_do(0, TOTAL + 4) !== 1) begin
      miscompares++;
      $display("FAIL ignored_data_over: got %0d pulses expected 1", cnt_do(0, TOTAL + 4));
    end
    vectors++;
    if (cnt_busy(0, TOTAL + 4) !== TOTAL) begin
      miscompares++;
      $display("FAIL ignored_busy_len: got %0d expected %0d", cnt_busy(0, TOTAL + 4), TOTAL);
    end
  endtask

  task automatic test_back_to_back(input logic [W-1:0] w1, input logic [W-1:0] w2);
    int e;
    int n;
    n = 2 * TOTAL + 4;
    start_word(w1);
    observe(n, TOTAL, 1, w2);
    e = wave_err(64'(w1), 0, 0, TOTAL + 1) + wave_err(64'(w2), TOTAL + 1, TOTAL + 1, n);
    vectors++;
    if (e !== 0) begin
      miscompares++;
      $display("FAIL b2b_wave: got %0d bad cycles expected 0", e);
    end
    vectors++;
    if (tr_txd[TOTAL + 1] !== 1'b0 || tr_busy[TOTAL + 1] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: got txd=%b busy=%b expected txd=0 busy=1", tr_txd[TOTAL + 1], tr_busy[TOTAL + 1]);
    end
    for (int f = 0; f < WB; f++) begin
      vectors++;
      if (decode_byte(TOTAL + 1, f) !== w2[8*f +: 8]) begin
        miscompares++;
        $display("FAIL b2b_byte%0d: got %h expected %h", f, decode_byte(TOTAL + 1, f), w2[8*f +: 8]);
      end
    end
    vectors++;
    if (cnt_busy(0, n) !== 2 * TOTAL) begin
      miscompares++;
      $display("FAIL b2b_busy_len: got %0d expected %0d", cnt_busy(0, n), 2 * TOTAL);
    end
    vectors++;
    if (cnt_do(0, n) !== 2 || tr_do[2 * TOTAL + 1] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_data_over: got %0d pulses expected 2", cnt_do(0, n));
    end
  endtask

  task automatic test_reset_mid(input logic [W-1:0] w);
    int z;
    start_word(w);
    observe(TOTAL + 4, 30, 2, '0);
    vectors++;
    if (tr_txd[31] !== 1'b1 || tr_busy[31] !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_next: got txd=%b busy=%b expected txd=1 busy=0", tr_txd[31], tr_busy[31]);
    end
    z = 0;
    for (int i = 31; i < TOTAL + 4; i++) if (tr_txd[i] !== 1'b1) z++;
    vectors++;
    if (z !== 0 || cnt_busy(31, TOTAL + 4) !== 0) begin
      miscompares++;
      $display("FAIL rstmid_idle: got %0d low txd, %0d busy cycles expected 0", z, cnt_busy(31, TOTAL + 4));
    end
    vectors++;
    if (cnt_do(0, TOTAL + 4) !== 0) begin
      miscompares++;
      $display("FAIL rstmid_data_over: got %0d pulses expected 0", cnt_do(0, TOTAL + 4));
    end
  endtask

  task automatic test_collision();
    rst = 1'b1;
    tx_start = 1'b1;
    data_in = '1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tx_start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_edge: got busy=%b txd=%b expected busy=0 txd=1", busy, txd);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_after: got busy=%b txd=%b expected busy=0 txd=1", busy, txd);
    end
  endtask

`ifdef UART_WORD_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] w, input logic exp_par);
    int e;
    start_word(w);
    observe(TOTAL + 3, -10, 0, '0);
    vectors++;
    if (tr_txd[9*C + C/2] !== exp_par) begin
      miscompares++;
      $display("FAIL parity_%h: got %b expected %b", w, tr_txd[9*C + C/2], exp_par);
    end
    vectors++;
    if (cnt_busy(0, TOTAL + 3) !== 44) begin
      miscompares++;
      $display("FAIL parity_busy_len_%h: got %0d expected 44", w, cnt_busy(0, TOTAL + 3));
    end
    e = wave_err(64'(w), 0, 0, TOTAL + 3);
    vectors++;
    if (e !== 0) begin
      miscompares++;
      $display("FAIL parity_wave_%h: got %0d bad cycles expected 0", w, e);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    tx_start = 1'b0;
    data_in = '0;
    test_reset();
    test_basic(W'(32'hA5C3_0F81));
    test_ignored(W'(32'hA5C3_0F81));
    test_back_to_back(W'(32'hA5C3_0F81), W'(32'h1234_5678));
    test_reset_mid(W'(32'hA5C3_0F81));
    test_basic(W'(32'h00FF_3C96));
    test_collision();
`ifdef UART_WORD_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Parametrised multi-byte UART transmitter: accepts a WORD_BYTES-wide word on a start pulse and serialises it as WORD_BYTES back-to-back 8N(STOP_BITS) frames, least-significant byte first, on a single TxD line. It has an internal bit-period counter instead of a free-running external baud tick, so every bit is exactly CLKS_PER_BIT clocks with phase locked to the start request. It has an explicit busy/done handshake, an optional parity bit and a synchronous reset. It sits between the word-producing datapath and the board TxD pin.

## Interface
- WORD_BYTES, 4: bytes per word; legal range 1..8.
- CLKS_PER_BIT, 434: clocks per serial bit (50 MHz / 115200); legal range ≥ 2.
- STOP_BITS, 2: stop bits per byte; legal values 1 or 2.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- tx_start  input  1  request; sampled only when busy=0.
- data_in  input  8*WORD_BYTES  word to send; sampled on the accepted tx_start cycle only.
- busy  output  1  high from the cycle after acceptance until the word is finished.
- data_over  output  1  one-cycle pulse when the last stop bit of the last byte completes.
- txd  output  1  serial line, registered; idle high.

## Operation
- Reset values: txd=1, busy=0, data_over=0. Reset also clears the state to IDLE and zeroes all counters. Reset mid-frame aborts the word; txd is 1 after the reset edge; no data_over is produced.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE
  - txd=1.
  - tx_start=1 loads data_in into the shift register, clears byte_idx, and enters START.
- START: txd=0 for one bit period, then DATA with bit_idx=0.
- DATA
  - txd = shift register bit 0; data is sent LSB first.
  - Each bit lasts one period; the register shifts right by 1 at the end of each period.
  - After bit_idx=7: go to PARITY when it is enabled, otherwise to STOP with stop_idx=0.
- STOP
  - txd=1 for STOP_BITS bit periods.
  - At the end of the last stop bit:
    - If byte_idx < WORD_BYTES-1: increment byte_idx and go to START. There is no idle gap between bytes.
    - Otherwise go to IDLE and pulse data_over.
- Byte order on the line: data_in[7:0] first, data_in[8*WORD_BYTES-1 -: 8] last.
- Bit-period counter
  - Width clog2(CLKS_PER_BIT).
  - Reloads to 0 on every state/bit transition.
  - A bit period ends when the counter reaches CLKS_PER_BIT-1.
- tx_start while busy=1 is ignored; it is not queued. data_in changes while busy have no effect.

## Timing
- Request accepted at edge k: busy=1 and txd=0 are both visible after edge k.
- Bits per byte: B = 1 + 8 + P + STOP_BITS, where P = 1 with parity, else 0.
- Busy duration: WORD_BYTES·B·CLKS_PER_BIT cycles exactly.
- Completion, after the final stop-bit cycle: busy=0 and data_over=1 for exactly one cycle; txd stays 1.
- tx_start asserted in the data_over cycle is accepted. This gives back-to-back words with no gap beyond the stop bits.
- tx_start and rst in the same cycle: rst wins; the request is dropped.

## Configuration
- Macro `UART_WORD_TX_PARITY_EN`.
- When defined:
  - Each byte carries a parity bit after data bit 7 and before the stop bits.
  - Parity is even: txd = XOR of the 8 data bits.
  - PARITY lasts one bit period.
- When undefined:
  - The PARITY state and its logic are absent.
  - The frame is 8 data bits with no parity.

## Test plan
- Reset and idle: hold rst 3 cycles, then idle 20 cycles → txd=1, busy=0, data_over=0 throughout.
- Basic word (CLKS_PER_BIT=4, WORD_BYTES=4, STOP_BITS=2, no parity)
  - Stimulus: tx_start pulse with data_in=32'hA5C3_0F81.
  - Line decodes as bytes 81, 0F, C3, A5, each with start 0 and two stop 1s.
  - busy is high exactly 4·11·4=176 cycles.
  - data_over is high exactly 1 cycle.
- Ignored request: second tx_start with 32'hFFFF_FFFF at cycle 50 of a busy word → line content unchanged; exactly one data_over pulse.
- Back-to-back: assert tx_start in the data_over cycle with 32'h1234_5678 → next start bit begins on the following cycle; bytes 78, 56, 34, 12 follow.
- Reset mid-frame: rst at cycle 30 of a word → txd=1, busy=0 next cycle; no data_over; a fresh word afterwards transmits correctly.
- Parity build (macro defined, WORD_BYTES=1, STOP_BITS=1): data_in=8'h07 → parity bit 1; data_in=8'h03 → parity bit 0; busy lasts 11·4=44 cycles.
